// File: rtl/instr_seq_pkg.sv
// Shared types and opcode constants for the instruction sequencer and its decoder.
package instr_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM
    } state_e;

    // ALU-class opcodes (cls = 0)
    localparam logic [2:0] ALU_OR    = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND_L = 3'b010;
    localparam logic [2:0] ALU_OR_L  = 3'b011;
    localparam logic [2:0] ALU_XOR_L = 3'b100;
    localparam logic [2:0] ALU_NOT_L = 3'b101;
    localparam logic [2:0] ALU_NOP   = 3'b110;
    localparam logic [2:0] ALU_MUL   = 3'b111;

    // Transfer-class kinds, selected by op[2:1] (cls = 1)
    localparam logic [1:0] XFER_LD     = 2'b10;
    localparam logic [1:0] XFER_REG_RD = 2'b00;
    localparam logic [1:0] XFER_LD_M   = 2'b01;
    localparam logic [1:0] XFER_ST_M   = 2'b11;

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational split of the instruction register into control requests;
// the sequencer decides when (and whether) each request reaches an output.
module instr_field_decode
    import instr_seq_pkg::*;
#(
    parameter int INSTR_W    = 16,
    parameter int MEM_ADDR_W = 10,
    parameter int REG_ADDR_W = 3
) (
    input  logic [INSTR_W-1:0]    ir_i,
    output logic                  alu_class_o,
    output logic [2:0]            alu_op_o,
    output logic                  aku_en_o,
    output logic                  aku_mux_en_o,
    output logic                  reg_ce_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    output logic [REG_ADDR_W-1:0] reg_addr_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o
);

    logic       cls;
    logic [2:0] op;
    // Bits between the opcode and the address field carry no meaning.
    logic       unused_ir;

    assign cls        = ir_i[INSTR_W-1];
    assign op         = ir_i[INSTR_W-2:INSTR_W-4];
    assign unused_ir  = ^ir_i;
    assign reg_addr_o = ir_i[REG_ADDR_W-1:0];
    assign mem_addr_o = ir_i[MEM_ADDR_W-1:0];

    always_comb begin
        alu_class_o  = ~cls;
        alu_op_o     = op;
        aku_en_o     = 1'b0;
        aku_mux_en_o = 1'b0;
        reg_ce_o     = 1'b0;
        mem_rd_o     = 1'b0;
        mem_wr_o     = 1'b0;
        if (!cls) begin
            case (op)
                ALU_OR, ALU_SUB, ALU_AND_L,
                ALU_OR_L, ALU_XOR_L, ALU_NOT_L: aku_en_o     = 1'b1;
                ALU_MUL:                        aku_mux_en_o = 1'b1;
                ALU_NOP:                        ;
            endcase
        end else begin
            case (op[2:1])
                XFER_LD:     reg_ce_o = 1'b1;
                XFER_REG_RD: ;
                XFER_LD_M:   mem_rd_o = 1'b1;
                XFER_ST_M:   mem_wr_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: fetches over a valid/request handshake, then
// drives registered ALU, register-file and data-memory control for one instruction.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int INSTR_W    = 16,
    parameter int PC_W       = 10,
    parameter int MEM_ADDR_W = 10,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic                  instr_req,
    output logic [PC_W-1:0]       pc,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instr_data,
    output logic [2:0]            alu_op,
    output logic                  aku_en,
    output logic                  aku_mux_en,
    output logic                  reg_ce,
    output logic [REG_ADDR_W-1:0] reg_addr,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic                  mem_ack,
    output logic                  busy
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_e                  state_q, state_d;
    logic [PC_W-1:0]         pc_q, pc_d;
    logic [INSTR_W-1:0]      ir_q, ir_d;
    logic                    instr_req_q, instr_req_d;
    logic [2:0]              alu_op_q, alu_op_d;
    logic                    aku_en_q, aku_en_d;
    logic                    aku_mux_en_q, aku_mux_en_d;
    logic                    reg_ce_q, reg_ce_d;
    logic [REG_ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                    mem_rd_q, mem_rd_d;
    logic                    mem_wr_q, mem_wr_d;
    logic                    busy_q, busy_d;
    logic                    done;

    logic                    dec_alu_class;
    logic [2:0]              dec_alu_op;
    logic                    dec_aku_en;
    logic                    dec_aku_mux_en;
    logic                    dec_reg_ce;
    logic                    dec_mem_rd;
    logic                    dec_mem_wr;
    logic [REG_ADDR_W-1:0]   dec_reg_addr;
    logic [MEM_ADDR_W-1:0]   dec_mem_addr;

    instr_field_decode #(
        .INSTR_W   (INSTR_W),
        .MEM_ADDR_W(MEM_ADDR_W),
        .REG_ADDR_W(REG_ADDR_W)
    ) u_decode (
        .ir_i        (ir_q),
        .alu_class_o (dec_alu_class),
        .alu_op_o    (dec_alu_op),
        .aku_en_o    (dec_aku_en),
        .aku_mux_en_o(dec_aku_mux_en),
        .reg_ce_o    (dec_reg_ce),
        .mem_rd_o    (dec_mem_rd),
        .mem_wr_o    (dec_mem_wr),
        .reg_addr_o  (dec_reg_addr),
        .mem_addr_o  (dec_mem_addr)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        alu_op_d   = alu_op_q;
        reg_addr_d = reg_addr_q;
        mem_addr_d = mem_addr_q;
        done       = 1'b0;

        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d    = S_EXEC;
                reg_addr_d = dec_reg_addr;
                mem_addr_d = dec_mem_addr;
                if (dec_alu_class) alu_op_d = dec_alu_op;
            end
            S_EXEC: begin
                if (dec_mem_rd || dec_mem_wr) state_d = S_MEM;
                else                          done    = 1'b1;
            end
            S_MEM:    if (mem_ack) done = 1'b1;
            default:  state_d = S_IDLE;
        endcase

        // run is only consulted between instructions, so dropping it never aborts one.
        if (done) begin
            pc_d    = pc_q + PC_ONE;
            state_d = run ? S_FETCH : S_IDLE;
        end

        // Outputs are derived from the next state so they line up with it once registered.
        instr_req_d  = (state_d == S_FETCH);
        busy_d       = (state_d != S_IDLE);
        aku_en_d     = (state_d == S_EXEC) && dec_aku_en;
        aku_mux_en_d = (state_d == S_EXEC) && dec_aku_mux_en;
        reg_ce_d     = (state_d == S_EXEC) && dec_reg_ce;
        mem_rd_d     = (state_d == S_MEM) && dec_mem_rd;
        mem_wr_d     = (state_d == S_MEM) && dec_mem_wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            instr_req_q  <= 1'b0;
            alu_op_q     <= '0;
            aku_en_q     <= 1'b0;
            aku_mux_en_q <= 1'b0;
            reg_ce_q     <= 1'b0;
            reg_addr_q   <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            instr_req_q  <= instr_req_d;
            alu_op_q     <= alu_op_d;
            aku_en_q     <= aku_en_d;
            aku_mux_en_q <= aku_mux_en_d;
            reg_ce_q     <= reg_ce_d;
            reg_addr_q   <= reg_addr_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            busy_q       <= busy_d;
        end
    end

    assign instr_req  = instr_req_q;
    assign pc         = pc_q;
    assign alu_op     = alu_op_q;
    assign aku_en     = aku_en_q;
    assign aku_mux_en = aku_mux_en_q;
    assign reg_ce     = reg_ce_q;
    assign reg_addr   = reg_addr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: directed and random instructions compared against a
// per-instruction behavioural model of pulses, transfer lengths, pc and held fields.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        instrValid;
    logic [15:0] instrData;
    logic        memAck;

    logic        instrReq;
    logic [9:0]  pc;
    logic [2:0]  aluOp;
    logic        akuEn;
    logic        akuMuxEn;
    logic        regCe;
    logic [2:0]  regAddr;
    logic [9:0]  memAddr;
    logic        memRd;
    logic        memWr;
    logic        busy;

    int          testCount = 0;
    int          failCount = 0;
    int          pcModel;
    logic [2:0]  aluModel;

    instr_sequencer #(
        .INSTR_W   (16),
        .PC_W      (10),
        .MEM_ADDR_W(10),
        .REG_ADDR_W(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .instr_req  (instrReq),
        .pc         (pc),
        .instr_valid(instrValid),
        .instr_data (instrData),
        .alu_op     (aluOp),
        .aku_en     (akuEn),
        .aku_mux_en (akuMuxEn),
        .reg_ce     (regCe),
        .reg_addr   (regAddr),
        .mem_addr   (memAddr),
        .mem_rd     (memRd),
        .mem_wr     (memWr),
        .mem_ack    (memAck),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_instr_req", instrReq, 0);
        checkOutput("rst_pc", pc, 0);
        checkOutput("rst_alu_op", aluOp, 0);
        checkOutput("rst_aku_en", akuEn, 0);
        checkOutput("rst_aku_mux_en", akuMuxEn, 0);
        checkOutput("rst_reg_ce", regCe, 0);
        checkOutput("rst_reg_addr", regAddr, 0);
        checkOutput("rst_mem_addr", memAddr, 0);
        checkOutput("rst_mem_rd", memRd, 0);
        checkOutput("rst_mem_wr", memWr, 0);
        checkOutput("rst_busy", busy, 0);
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at a negedge in FETCH.
    // Cycle n counts negedges after the accepting edge: DECODE is n=1, EXEC n=2.
    task automatic applyStimulus(input logic [15:0] instr, input int fetchWait,
                                 input int ackWait, input bit runAfter);
        int   n = 1;
        int   akuCnt = 0, muxCnt = 0, regCnt = 0, rdCnt = 0, wrCnt = 0;
        int   akuAt = 0, muxAt = 0, regAt = 0;
        bit   both = 0, addrBad = 0, done = 0;
        logic cls = instr[15];
        logic [2:0] op = instr[14:12];
        bit   expAku = !cls && (op < 3'd6);
        bit   expMux = !cls && (op == 3'd7);
        bit   expReg = cls && (op[2:1] == 2'b10);
        bit   expRd  = cls && (op[2:1] == 2'b01);
        bit   expWr  = cls && (op[2:1] == 2'b11);
        logic [9:0] addrField = instr[9:0];
        logic [2:0] regField  = instr[2:0];

        checkOutput("fetch_req", instrReq, 1);
        checkOutput("fetch_pc", pc, pcModel);
        instrValid = 1'b0;
        for (int w = 0; w < fetchWait; w++) begin
            instrData = 16'($urandom);
            memAck    = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checkOutput("fetch_req_wait", instrReq, 1);
        instrValid = 1'b1;
        instrData  = instr;
        @(negedge clk);

        while (!done && n < 40) begin
            if (akuEn)    begin akuCnt++; akuAt = n; end
            if (akuMuxEn) begin muxCnt++; muxAt = n; end
            if (regCe)    begin regCnt++; regAt = n; end
            if (memRd) rdCnt++;
            if (memWr) wrCnt++;
            if (memRd && memWr) both = 1;
            if ((memRd || memWr) && memAddr !== addrField) addrBad = 1;
            if (instrReq || !busy) begin
                done = 1;
            end else begin
                if (n == 2) run = runAfter;
                // Junk on instr_valid / mem_ack outside their states must be ignored.
                instrValid = 1'($urandom_range(0, 1));
                instrData  = 16'($urandom);
                if (memRd || memWr)
                    memAck = ((memRd ? rdCnt : wrCnt) == ackWait);
                else
                    memAck = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
        end
        instrValid = 1'b0;
        memAck     = 1'b0;

        pcModel = (pcModel + 1) % 1024;
        if (!cls) aluModel = op;

        checkOutput("instr_done", done, 1);
        checkOutput("instr_cycles", n, (expRd || expWr) ? ackWait + 3 : 3);
        checkOutput("aku_en_pulses", akuCnt, expAku);
        checkOutput("aku_mux_pulses", muxCnt, expMux);
        checkOutput("reg_ce_pulses", regCnt, expReg);
        if (expAku) checkOutput("aku_en_cycle", akuAt, 2);
        if (expMux) checkOutput("aku_mux_cycle", muxAt, 2);
        if (expReg) checkOutput("reg_ce_cycle", regAt, 2);
        checkOutput("mem_rd_cycles", rdCnt, expRd ? ackWait : 0);
        checkOutput("mem_wr_cycles", wrCnt, expWr ? ackWait : 0);
        checkOutput("mem_rd_wr_both", both, 0);
        checkOutput("mem_addr_during_xfer", addrBad, 0);
        checkOutput("reg_addr", regAddr, regField);
        checkOutput("mem_addr", memAddr, addrField);
        checkOutput("alu_op", aluOp, aluModel);
        checkOutput("pc_after", pc, pcModel);

        if (runAfter) begin
            checkOutput("next_fetch_req", instrReq, 1);
        end else begin
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_instr_req", instrReq, 0);
            repeat (2) @(negedge clk);
            checkOutput("idle_pc_held", pc, pcModel);
            checkOutput("idle_busy_held", busy, 0);
            run = 1'b1;
            @(negedge clk);
            checkOutput("restart_instr_req", instrReq, 1);
        end
    endtask

    initial begin
        int wait10;
        rst        = 1'b1;
        run        = 1'b0;
        instrValid = 1'b0;
        instrData  = '0;
        memAck     = 1'b0;
        pcModel    = 0;
        aluModel   = 3'd0;
        repeat (2) @(negedge clk);
        checkResetState();

        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_without_run", busy, 0);
        run = 1'b1;
        @(negedge clk);
        checkOutput("run_start_req", instrReq, 1);
        checkOutput("run_start_busy", busy, 1);

        applyStimulus(16'h1000, 0, 1, 1);  // SUB
        applyStimulus(16'h7000, 0, 1, 1);  // MUL
        applyStimulus(16'h6000, 1, 1, 1);  // NOP
        applyStimulus(16'hF155, 0, 3, 1);  // store to 0x155
        applyStimulus(16'hC005, 2, 1, 1);  // LD reg 5
        applyStimulus(16'hA3FF, 0, 2, 1);  // load from 0x3FF
        applyStimulus(16'hE000, 0, 1, 1);  // store to 0x000, single-cycle ack

        while (pcModel != 1023) begin
            applyStimulus(16'($urandom), $urandom_range(0, 3), $urandom_range(1, 4),
                          $urandom_range(0, 9) != 0);
        end

        // NOP at the top address wraps pc, and run falls during EXEC.
        applyStimulus(16'h6000, 0, 1, 0);
        checkOutput("pc_wrapped", pc, 0);

        // Reset in the middle of a memory read, without any ack.
        instrValid = 1'b1;
        instrData  = 16'hA3FF;
        @(negedge clk);
        instrValid = 1'b0;
        wait10 = 0;
        while (!memRd && wait10 < 10) begin
            @(negedge clk);
            wait10++;
        end
        checkOutput("mem_rd_before_reset", memRd, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkResetState();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_req", instrReq, 1);
        checkOutput("post_reset_pc", pc, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
